// File: rtl/step_hex_formatter.sv
// Snapshot formatter: latches X/Y/Z/E positions and streams them as one ASCII line
// of uppercase hex fields separated by spaces and terminated by LF, over valid/ready.
module step_hex_formatter #(
  parameter int X_NIBBLES    = 4,
  parameter int Y_NIBBLES    = 4,
  parameter int Z_NIBBLES    = 5,
  parameter int E_NIBBLES    = 5,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*X_NIBBLES-1:0] x_pos,
  input  logic [4*Y_NIBBLES-1:0] y_pos,
  input  logic [4*Z_NIBBLES-1:0] z_pos,
  input  logic [4*E_NIBBLES-1:0] e_pos,
  input  logic                   snap_req,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int TOTAL_NIB = X_NIBBLES + Y_NIBBLES + Z_NIBBLES + E_NIBBLES;
  localparam int SHIFT_W   = 4 * TOTAL_NIB;
  localparam int MAX_XY    = (X_NIBBLES > Y_NIBBLES) ? X_NIBBLES : Y_NIBBLES;
  localparam int MAX_ZE    = (Z_NIBBLES > E_NIBBLES) ? Z_NIBBLES : E_NIBBLES;
  localparam int MAX_NIB   = (MAX_XY > MAX_ZE) ? MAX_XY : MAX_ZE;
  localparam int NIB_W     = $clog2(MAX_NIB + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEX  = 2'd1,
    SEP  = 2'd2,
    EOL  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [SHIFT_W-1:0]   shift_reg, shift_next;
  logic [1:0]           field_reg, field_next;
  logic [NIB_W-1:0]     nib_reg, nib_next;
  logic [7:0]           byte_reg, byte_next;
  logic                 valid_reg, valid_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 overrun_reg, overrun_next;

  logic [SHIFT_W-1:0]   snapshot;
  logic                 xfer;
  logic                 load;
  logic [NIB_W-1:0]     nib_inc;
  logic                 last_nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [NIB_W-1:0] field_len(input logic [1:0] f);
    case (f)
      2'd0:    return NIB_W'(X_NIBBLES);
      2'd1:    return NIB_W'(Y_NIBBLES);
      2'd2:    return NIB_W'(Z_NIBBLES);
      default: return NIB_W'(E_NIBBLES);
    endcase
  endfunction

  assign snapshot = {x_pos, y_pos, z_pos, e_pos};
  assign xfer     = valid_reg & tx_ready;
  assign nib_inc  = nib_reg + NIB_W'(1);
  assign last_nib = (nib_inc == field_len(field_reg));

  // A new snapshot is taken from IDLE on request, or straight after the LF when auto-restarting.
  assign load = ((state_reg == IDLE) && snap_req) ||
                ((state_reg == EOL) && xfer && AUTO_RESTART);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    field_next   = field_reg;
    nib_next     = nib_reg;
    byte_next    = byte_reg;
    valid_next   = valid_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg | (snap_req & busy_reg);

    // Bytes after a transfer are presented one cycle later from the updated registers,
    // so tx_byte/tx_valid never depend combinationally on tx_ready.
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
      end
      HEX: begin
        if (xfer) begin
          valid_next = 1'b0;
          shift_next = shift_reg << 4;
          nib_next   = nib_inc;
          if (last_nib) begin
            state_next = (field_reg == 2'd3) ? EOL : SEP;
          end
        end else if (!valid_reg) begin
          valid_next = 1'b1;
          byte_next  = hex_ascii(shift_reg[SHIFT_W-1 -: 4]);
        end
      end
      SEP: begin
        if (xfer) begin
          valid_next = 1'b0;
          field_next = field_reg + 2'd1;
          nib_next   = '0;
          state_next = HEX;
        end else if (!valid_reg) begin
          valid_next = 1'b1;
          byte_next  = 8'h20;
        end
      end
      EOL: begin
        if (xfer) begin
          done_next  = 1'b1;
          valid_next = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (!valid_reg) begin
          valid_next = 1'b1;
          byte_next  = 8'h0A;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    // Loading presents the first digit immediately, giving single-cycle latency.
    if (load) begin
      shift_next = snapshot;
      field_next = 2'd0;
      nib_next   = '0;
      state_next = HEX;
      busy_next  = 1'b1;
      valid_next = 1'b1;
      byte_next  = hex_ascii(snapshot[SHIFT_W-1 -: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      field_reg   <= 2'd0;
      nib_reg     <= '0;
      byte_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      field_reg   <= field_next;
      nib_reg     <= nib_next;
      byte_reg    <= byte_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign tx_byte    = byte_reg;
  assign tx_valid   = valid_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_step_hex_formatter.sv
// Bench for step_hex_formatter: table-driven lines checked through a byte scoreboard,
// plus hand-written sequences for overrun, async reset and auto-restart.
module tb_step_hex_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_pos, y_pos;
  logic [19:0] z_pos, e_pos;
  logic        snap_req, tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid, busy, frame_done, overrun;

  logic        snap_req_a, tx_ready_a;
  logic [7:0]  tx_byte_a;
  logic        tx_valid_a, busy_a, frame_done_a, overrun_a;

  always #5 clk = ~clk;

  step_hex_formatter #(.AUTO_RESTART(1'b0)) dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .z_pos(z_pos), .e_pos(e_pos),
    .snap_req(snap_req), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  step_hex_formatter #(.AUTO_RESTART(1'b1)) dut_auto (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .z_pos(z_pos), .e_pos(e_pos),
    .snap_req(snap_req_a), .tx_byte(tx_byte_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .frame_done(frame_done_a), .overrun(overrun_a)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [19:0] z;
    logic [19:0] e;
    bit          rnd;
    string       line;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         passed = 0;
  int         xfer_cnt = 0;
  int         fd_cnt = 0;
  int         line_no = 0;
  bit         fd_due = 1'b0;
  bit         prev_v = 1'b0;
  bit         prev_r = 1'b0;
  logic [7:0] prev_b = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [15:0] x, input logic [15:0] y, input logic [19:0] z,
                         input logic [19:0] e, input bit rnd, input string line);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.e = e; v.rnd = rnd; v.line = line;
    vecs.push_back(v);
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  function automatic logic pick_ready(input bit rnd);
    return rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // Called once per cycle at the falling edge, after tx_ready for the next edge is set.
  task automatic mon0();
    logic [7:0] exp_b;
    if (prev_v && !prev_r) begin
      check("hold_valid", tx_valid, 1);
      check("hold_byte", tx_byte, prev_b);
    end
    if (fd_due) begin
      check("frame_done_pulse", frame_done, 1);
      check("busy_fall", busy, 0);
      fd_due = 1'b0;
    end
    if (frame_done) fd_cnt++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", tx_valid, 0);
      end else begin
        exp_b = exp_q.pop_front();
        check("byte", tx_byte, exp_b);
        xfer_cnt++;
        if (exp_b == 8'h0A) fd_due = 1'b1;
      end
    end
    prev_v = tx_valid;
    prev_r = tx_ready;
    prev_b = tx_byte;
  endtask

  task automatic snap0(input bit rnd);
    xfer_cnt = 0;
    @(negedge clk);
    snap_req = 1'b1;
    tx_ready = pick_ready(rnd);
    mon0();
    @(negedge clk);
    snap_req = 1'b0;
    check("first_byte_latency", tx_valid, 1);
    check("busy_rise", busy, 1);
    tx_ready = pick_ready(rnd);
    mon0();
  endtask

  task automatic run0(input bit rnd, input int snap_at, input int budget);
    int n = 0;
    bit snapped = 1'b0;
    while ((exp_q.size() != 0 || fd_due) && n < budget) begin
      @(negedge clk);
      snap_req = (snap_at >= 0) && !snapped && (xfer_cnt == snap_at);
      if (snap_req) snapped = 1'b1;
      tx_ready = pick_ready(rnd);
      mon0();
      n++;
    end
    snap_req = 1'b0;
    if (n >= budget) check("line_timeout", exp_q.size(), 0);
    line_no++;
    $display("line %0d: %0d bytes accepted in %0d cycles", line_no, xfer_cnt, n + 2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_before;
    int xfer1, fd1, n;
    bit lf_prev;
    string auto_line;

    rst = 1'b1; snap_req = 1'b0; tx_ready = 1'b0;
    snap_req_a = 1'b0; tx_ready_a = 1'b0;
    x_pos = '0; y_pos = '0; z_pos = '0; e_pos = '0;

    add_vec(16'h12AB, 16'h00FF, 20'h0001C, 20'hFFFFF, 1'b0, "12AB 00FF 0001C FFFFF\n");
    add_vec(16'h12AB, 16'h00FF, 20'h0001C, 20'hFFFFF, 1'b1, "12AB 00FF 0001C FFFFF\n");
    add_vec(16'h0123, 16'h4567, 20'h89ABC, 20'hDEF01, 1'b0, "0123 4567 89ABC DEF01\n");
    add_vec(16'hFEDC, 16'hBA98, 20'h76543, 20'h210A5, 1'b1, "FEDC BA98 76543 210A5\n");
    add_vec(16'hA5A5, 16'h0F0F, 20'h3C3C3, 20'h00009, 1'b1, "A5A5 0F0F 3C3C3 00009\n");

    repeat (2) @(negedge clk);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Table-driven lines
    foreach (vecs[i]) begin
      x_pos = vecs[i].x; y_pos = vecs[i].y; z_pos = vecs[i].z; e_pos = vecs[i].e;
      fd_before = fd_cnt;
      push_line(vecs[i].line);
      snap0(vecs[i].rnd);
      run0(vecs[i].rnd, -1, 400);
      check("frame_done_count", fd_cnt - fd_before, 1);
      check("busy_after_line", busy, 0);
      check("overrun_clear", overrun, 0);
      check("line_length", xfer_cnt, 22);
      @(negedge clk);
      tx_ready = 1'b0;
      mon0();
    end

    // Positions change after the snapshot: the line in flight keeps the old X
    x_pos = 16'h12AB; y_pos = 16'h00FF; z_pos = 20'h0001C; e_pos = 20'hFFFFF;
    push_line("12AB 00FF 0001C FFFFF\n");
    snap0(1'b0);
    @(negedge clk);
    x_pos = 16'h9999;
    tx_ready = 1'b1;
    mon0();
    run0(1'b0, -1, 400);
    push_line("9999 00FF 0001C FFFFF\n");
    snap0(1'b0);
    run0(1'b0, -1, 400);

    // snap_req mid-line: line finishes untouched, overrun sticks, nothing restarts
    x_pos = 16'h0123; y_pos = 16'h4567; z_pos = 20'h89ABC; e_pos = 20'hDEF01;
    push_line("0123 4567 89ABC DEF01\n");
    snap0(1'b0);
    x_pos = 16'hAAAA;
    run0(1'b0, 7, 400);
    check("overrun_set", overrun, 1);
    repeat (8) begin
      @(negedge clk);
      tx_ready = 1'b1;
      mon0();
    end
    check("no_second_line_valid", tx_valid, 0);
    check("no_second_line_busy", busy, 0);
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset while byte 10 is offered
    x_pos = 16'h12AB; y_pos = 16'h00FF; z_pos = 20'h0001C; e_pos = 20'hFFFFF;
    push_line("12AB 00FF 0001C FFFFF\n");
    snap0(1'b0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (xfer_cnt == 9 && tx_valid) break;
      tx_ready = 1'b1;
      mon0();
      n++;
    end
    check("reset_point_reached", xfer_cnt, 9);
    rst = 1'b1;
    #1;
    check("async_rst_valid", tx_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_overrun", overrun, 0);
    exp_q.delete();
    fd_due = 1'b0;
    prev_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    x_pos = '0; y_pos = '0; z_pos = '0; e_pos = '0;
    push_line("0000 0000 00000 00000\n");
    snap0(1'b0);
    run0(1'b0, -1, 400);
    check("zeros_length", xfer_cnt, 22);

    // Auto-restart: back-to-back lines, first digit straight after each LF
    x_pos = 16'h12AB; y_pos = 16'h00FF; z_pos = 20'h0001C; e_pos = 20'hFFFFF;
    auto_line = "12AB 00FF 0001C FFFFF\n";
    @(negedge clk);
    tx_ready_a = 1'b1;
    snap_req_a = 1'b1;
    xfer1 = 0; fd1 = 0; n = 0; lf_prev = 1'b0;
    while (xfer1 < 66 && n < 400) begin
      @(negedge clk);
      snap_req_a = 1'b0;
      check("auto_busy", busy_a, 1);
      if (frame_done_a) fd1++;
      if (lf_prev) begin
        check("auto_no_gap_valid", tx_valid_a, 1);
        check("auto_first_digit", tx_byte_a, auto_line[0]);
        lf_prev = 1'b0;
      end
      if (tx_valid_a) begin
        check("auto_byte", tx_byte_a, auto_line[xfer1 % 22]);
        if (tx_byte_a == 8'h0A) lf_prev = 1'b1;
        xfer1++;
      end
      n++;
    end
    @(negedge clk);
    if (frame_done_a) fd1++;
    check("auto_bytes", xfer1, 66);
    check("auto_frame_done_count", fd1, 3);
    check("auto_overrun", overrun_a, 0);
    $display("auto-restart: %0d bytes, %0d frames in %0d cycles", xfer1, fd1, n);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
